// File: rtl/ddr_ctrl_pkg.sv
// rtl/ddr_ctrl_pkg.sv - shared DDR controller command codes, recodes, block reasons and timing defaults
package ddr_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    // Last-command code reported by each bank's tP_counter
    localparam logic [2:0] RC_IDLE = 3'd0;
    localparam logic [2:0] RC_WR   = 3'd1;
    localparam logic [2:0] RC_PRE  = 3'd2;
    localparam logic [2:0] RC_ACT  = 3'd3;
    localparam logic [2:0] RC_RD   = 3'd4;
    localparam logic [2:0] RC_WRA  = 3'd5;
    localparam logic [2:0] RC_RDA  = 3'd6;

    typedef enum logic [2:0] {
        BR_OK   = 3'd0,
        BR_BANK = 3'd1,
        BR_TRRD = 3'd2,
        BR_TFAW = 3'd3,
        BR_TCCD = 3'd4,
        BR_TWTR = 3'd5
    } block_reason_e;

    localparam int DEF_NUM_BANKS  = 8;
    localparam int DEF_CYCLE_TRRD = 4;
    localparam int DEF_CYCLE_TFAW = 20;
    localparam int DEF_CYCLE_TCCD = 4;
    localparam int DEF_CYCLE_TWTR = 4;

    // Bank has no open row: idle, precharged, or closed by an auto-precharge
    function automatic logic rc_closed(input logic [2:0] rc);
        return (rc == RC_IDLE) || (rc == RC_PRE) || (rc == RC_WRA) || (rc == RC_RDA);
    endfunction

    // Bank has an open row: just activated, or a plain RD/WR since
    function automatic logic rc_open(input logic [2:0] rc);
        return (rc == RC_ACT) || (rc == RC_RD) || (rc == RC_WR);
    endfunction

endpackage

// File: rtl/cmd_issue_gate_faw_window.sv
// rtl/cmd_issue_gate_faw_window.sv - four-slot rolling tFAW window for ACT commands
module faw_window
    import ddr_ctrl_pkg::*;
#(
    parameter int CYCLE_TFAW = DEF_CYCLE_TFAW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic act_load,
    output logic act_ok
);

    logic [4:0] r_slot [4];
    logic       w_any_free;
    logic [1:0] w_free_idx;

    // Find the lowest-index expired slot; ACT is only legal if one exists
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_slot[i] == 5'd0) begin
                w_any_free = 1'b1;
                w_free_idx = 2'(i);
            end
        end
        act_ok = w_any_free;
    end

    // Claim the free slot on an ACT, every other slot counts down toward 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (act_load && w_any_free && (w_free_idx == 2'(i))) begin
                    r_slot[i] <= 5'(CYCLE_TFAW - 1);
                end else if (r_slot[i] != 5'd0) begin
                    r_slot[i] <= r_slot[i] - 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cmd_issue_gate.sv
// rtl/cmd_issue_gate.sv - final cross-bank timing gate between scheduler and DDR command FSM
module cmd_issue_gate
    import ddr_ctrl_pkg::*;
#(
    parameter int NUM_BANKS  = DEF_NUM_BANKS,
    parameter int CYCLE_TRRD = DEF_CYCLE_TRRD,
    parameter int CYCLE_TFAW = DEF_CYCLE_TFAW,
    parameter int CYCLE_TCCD = DEF_CYCLE_TCCD,
    parameter int CYCLE_TWTR = DEF_CYCLE_TWTR,
    parameter int BA_BITS    = $clog2(NUM_BANKS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [2:0]             req_cmd,
    input  logic [BA_BITS-1:0]     req_bank,
    input  logic                   req_auto_pre,
    output logic                   req_ready,
    input  logic [NUM_BANKS*5-1:0] tp_ba_cnt,
    input  logic [NUM_BANKS*6-1:0] tras_cnt,
    input  logic [NUM_BANKS*3-1:0] recode,
    output logic                   issue_valid,
    output logic [2:0]             issue_cmd,
    output logic [BA_BITS-1:0]     issue_bank,
    output logic                   issue_auto_pre,
    output logic [2:0]             block_reason
);

    localparam int CW = 8;

    logic [CW-1:0]   r_trrd_cnt;
    logic [CW-1:0]   r_tccd_cnt;
    logic [CW-1:0]   r_twtr_cnt;

    logic [4:0]      w_tp   [NUM_BANKS];
    logic [5:0]      w_tras [NUM_BANKS];
    logic [2:0]      w_rc   [NUM_BANKS];
    logic            w_all_idle;
    logic            w_act_ok;
    logic            w_legal;
    block_reason_e   w_reason;
    logic            w_accept;
    logic            w_is_act;
    logic            w_is_col;
    logic            w_is_wr;

    // Unpack the per-bank counter buses and check the all-bank REF condition
    always_comb begin
        w_all_idle = 1'b1;
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_tp[i]   = tp_ba_cnt[5*i +: 5];
            w_tras[i] = tras_cnt[6*i +: 6];
            w_rc[i]   = recode[3*i +: 3];
            if ((w_tp[i] != 5'd0) || !rc_closed(w_rc[i])) begin
                w_all_idle = 1'b0;
            end
        end
    end

    // Legality mux; the first failing check in bank, tRRD, tFAW, tCCD, tWTR order is reported
    always_comb begin
        w_legal  = 1'b0;
        w_reason = BR_OK;
        case (cmd_e'(req_cmd))
            CMD_NOP: begin
                w_legal  = 1'b0;
                w_reason = BR_OK;
            end
            CMD_ACT: begin
                if ((w_tp[req_bank] != 5'd0) || !rc_closed(w_rc[req_bank])) w_reason = BR_BANK;
                else if (r_trrd_cnt != '0)                                 w_reason = BR_TRRD;
                else if (!w_act_ok)                                        w_reason = BR_TFAW;
                else                                                       w_legal  = 1'b1;
            end
            CMD_RD: begin
                if ((w_tp[req_bank] != 5'd0) || !rc_open(w_rc[req_bank])) w_reason = BR_BANK;
                else if (r_tccd_cnt != '0)                               w_reason = BR_TCCD;
                else if (r_twtr_cnt != '0)                               w_reason = BR_TWTR;
                else                                                     w_legal  = 1'b1;
            end
            CMD_WR: begin
                if ((w_tp[req_bank] != 5'd0) || !rc_open(w_rc[req_bank])) w_reason = BR_BANK;
                else if (r_tccd_cnt != '0)                               w_reason = BR_TCCD;
                else                                                     w_legal  = 1'b1;
            end
            CMD_PRE: begin
                if ((w_tp[req_bank] != 5'd0) || (w_tras[req_bank] != 6'd0) ||
                    !rc_open(w_rc[req_bank]))                            w_reason = BR_BANK;
                else                                                     w_legal  = 1'b1;
            end
            CMD_REF: begin
                if (!w_all_idle) w_reason = BR_BANK;
                else             w_legal  = 1'b1;
            end
            default: begin
                w_legal  = 1'b0;
                w_reason = BR_BANK;
            end
        endcase
    end

    assign req_ready = w_legal;
    assign w_accept  = req_valid & w_legal;
    assign w_is_act  = w_accept && (req_cmd == CMD_ACT);
    assign w_is_wr   = w_accept && (req_cmd == CMD_WR);
    assign w_is_col  = w_accept && ((req_cmd == CMD_RD) || (req_cmd == CMD_WR));

    faw_window #(
        .CYCLE_TFAW (CYCLE_TFAW)
    ) u_faw_window (
        .clk      (clk),
        .rst_n    (rst_n),
        .act_load (w_is_act),
        .act_ok   (w_act_ok)
    );

    // Cross-bank spacing counters: load on the issuing command, otherwise count down to 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_trrd_cnt <= '0;
            r_tccd_cnt <= '0;
            r_twtr_cnt <= '0;
        end else begin
            if (w_is_act)               r_trrd_cnt <= CW'(CYCLE_TRRD - 1);
            else if (r_trrd_cnt != '0)  r_trrd_cnt <= r_trrd_cnt - 1'b1;

            if (w_is_col)               r_tccd_cnt <= CW'(CYCLE_TCCD - 1);
            else if (r_tccd_cnt != '0)  r_tccd_cnt <= r_tccd_cnt - 1'b1;

            if (w_is_wr)                r_twtr_cnt <= CW'(CYCLE_TWTR - 1);
            else if (r_twtr_cnt != '0)  r_twtr_cnt <= r_twtr_cnt - 1'b1;
        end
    end

    // Issue registers: one-cycle valid pulse, payload held between issues
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid    <= 1'b0;
            issue_cmd      <= 3'd0;
            issue_bank     <= '0;
            issue_auto_pre <= 1'b0;
            block_reason   <= 3'd0;
        end else begin
            issue_valid  <= w_accept;
            block_reason <= req_valid ? w_reason : BR_OK;
            if (w_accept) begin
                issue_cmd      <= req_cmd;
                issue_bank     <= req_bank;
                issue_auto_pre <= req_auto_pre;
            end
        end
    end

endmodule
